// File: rtl/clint_timer_if.sv
// Register request/response port between the bus bridge (master) and the CLINT timer (slave).
// Requests and responses each use a valid/ready handshake, with at most one transaction outstanding.
interface clint_timer_if #(
    parameter int XLEN = 64
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [15:0]       ReqAdr;
    logic [XLEN-1:0]   ReqWData;
    logic [XLEN/8-1:0] ReqStrb;
    logic              RspValid;
    logic              RspReady;
    logic [XLEN-1:0]   RspRData;
    logic              RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqAdr, ReqWData, ReqStrb, RspReady,
        input  ReqReady, RspValid, RspRData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAdr, ReqWData, ReqStrb, RspReady,
        output ReqReady, RspValid, RspRData, RspErr
    );
endinterface

// File: rtl/clint_timer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp and registered timer interrupt behind a req/rsp port.
// Response appears 1 cycle after acceptance; ReqReady drops while a response is held unconsumed.
module clint_timer #(
    parameter int XLEN         = 64,
    parameter int TIMEBASE_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    clint_timer_if.slave bus,
    output logic [63:0] MTIME_CLINT,
    output logic        MTimerInt
);
    localparam int            PW       = (TIMEBASE_DIV > 1) ? $clog2(TIMEBASE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TIMEBASE_DIV - 1);
    localparam logic [15:0]   ADR_CMP  = 16'h4000;
    localparam logic [15:0]   ADR_TIME = 16'hBFF8;

    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            int_q, int_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic [XLEN-1:0] rsp_rdat_q, rsp_rdat_d;
    logic            rsp_err_q, rsp_err_d;

    logic        tick, accept, aligned, sel_cmp, sel_time, hit, half_hi, wr_hit;
    logic [63:0] wdat64, wmask64, rd64;
    logic [7:0]  strb64;

    // Address decode; in 32-bit mode ReqAdr[2] picks the upper half of a 64-bit register.
    always_comb begin
        tick     = (prescaler_q == PRE_LAST);
        accept   = bus.ReqValid & bus.ReqReady;
        aligned  = (XLEN == 64) ? (bus.ReqAdr[2:0] == 3'b000) : (bus.ReqAdr[1:0] == 2'b00);
        sel_cmp  = ({bus.ReqAdr[15:3], 3'b000} == ADR_CMP);
        sel_time = ({bus.ReqAdr[15:3], 3'b000} == ADR_TIME);
        hit      = aligned & (sel_cmp | sel_time);
        half_hi  = (XLEN == 32) && bus.ReqAdr[2];
        wr_hit   = accept & bus.ReqWrite & hit;

        wdat64 = 64'(bus.ReqWData);
        strb64 = 8'(bus.ReqStrb);
        if (half_hi) begin
            wdat64 = wdat64 << 32;
            strb64 = strb64 << 4;
        end
        wmask64 = '0;
        for (int i = 0; i < 8; i++) begin
            wmask64[i*8 +: 8] = {8{strb64[i]}};
        end

        rd64 = sel_time ? mtime_q : mtimecmp_q;
        if (half_hi) begin
            rd64 = rd64 >> 32;
        end
    end

    always_comb begin
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;

        // A register write replaces the tick; unwritten bytes keep their pre-tick value.
        mtime_d = mtime_q + 64'(tick);
        if (wr_hit && sel_time) begin
            mtime_d = (mtime_q & ~wmask64) | (wdat64 & wmask64);
        end
        mtimecmp_d = mtimecmp_q;
        if (wr_hit && sel_cmp) begin
            mtimecmp_d = (mtimecmp_q & ~wmask64) | (wdat64 & wmask64);
        end

        // Compare on the current registered values, so the interrupt lags the compare by one cycle.
        int_d = (mtime_q >= mtimecmp_q);

        rsp_vld_d  = accept | (rsp_vld_q & ~bus.RspReady);
        rsp_rdat_d = rsp_rdat_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            rsp_err_d  = ~hit;
            rsp_rdat_d = (hit & ~bus.ReqWrite) ? XLEN'(rd64) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_q <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            int_q       <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdat_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            int_q       <= int_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdat_q  <= rsp_rdat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.ReqReady = ~rsp_vld_q | bus.RspReady;
    assign bus.RspValid = rsp_vld_q;
    assign bus.RspRData = rsp_rdat_q;
    assign bus.RspErr   = rsp_err_q;
    assign MTIME_CLINT  = mtime_q;
    assign MTimerInt    = int_q;
endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: 64-bit DIV=1, 64-bit DIV=4 and 32-bit DIV=1 instances share one clock and reset.
module tb_clint_timer;
    logic clk;
    logic reset;

    clint_timer_if #(.XLEN(64)) if64 ();
    clint_timer_if #(.XLEN(64)) if4 ();
    clint_timer_if #(.XLEN(32)) if32 ();

    logic [63:0] mt64, mt4, mt32;
    logic        int64, int4, int32;

    clint_timer #(.XLEN(64), .TIMEBASE_DIV(1)) u_t64 (
        .clk(clk), .reset(reset), .bus(if64.slave), .MTIME_CLINT(mt64), .MTimerInt(int64));
    clint_timer #(.XLEN(64), .TIMEBASE_DIV(4)) u_t4 (
        .clk(clk), .reset(reset), .bus(if4.slave), .MTIME_CLINT(mt4), .MTimerInt(int4));
    clint_timer #(.XLEN(32), .TIMEBASE_DIV(1)) u_t32 (
        .clk(clk), .reset(reset), .bus(if32.slave), .MTIME_CLINT(mt32), .MTimerInt(int32));

    int          sel;
    logic        req_vld, req_wr, rsp_rdy;
    logic [15:0] req_adr;
    logic [63:0] req_wdat;
    logic [7:0]  req_strb;
    logic        req_rdy, rsp_vld, rsp_err;
    logic [63:0] rsp_rdat;
    int          n_vec, n_bad;
    longint      cyc;

    assign if64.ReqValid = req_vld && (sel == 0);
    assign if4.ReqValid  = req_vld && (sel == 1);
    assign if32.ReqValid = req_vld && (sel == 2);
    assign if64.RspReady = (sel == 0) ? rsp_rdy : 1'b1;
    assign if4.RspReady  = (sel == 1) ? rsp_rdy : 1'b1;
    assign if32.RspReady = (sel == 2) ? rsp_rdy : 1'b1;
    assign if64.ReqWrite = req_wr;
    assign if4.ReqWrite  = req_wr;
    assign if32.ReqWrite = req_wr;
    assign if64.ReqAdr   = req_adr;
    assign if4.ReqAdr    = req_adr;
    assign if32.ReqAdr   = req_adr;
    assign if64.ReqWData = req_wdat;
    assign if4.ReqWData  = req_wdat;
    assign if32.ReqWData = req_wdat[31:0];
    assign if64.ReqStrb  = req_strb;
    assign if4.ReqStrb   = req_strb;
    assign if32.ReqStrb  = req_strb[3:0];

    always_comb begin
        req_rdy  = if64.ReqReady;
        rsp_vld  = if64.RspValid;
        rsp_err  = if64.RspErr;
        rsp_rdat = if64.RspRData;
        case (sel)
            1: begin
                req_rdy = if4.ReqReady; rsp_vld = if4.RspValid;
                rsp_err = if4.RspErr;   rsp_rdat = if4.RspRData;
            end
            2: begin
                req_rdy = if32.ReqReady; rsp_vld = if32.RspValid;
                rsp_err = if32.RspErr;   rsp_rdat = 64'(if32.RspRData);
            end
            default: ;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Posedges seen out of reset: equals mtime of an unwritten DIV=1 timer.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input int s, input logic wr, input logic [15:0] adr,
                          input logic [63:0] wdat, input logic [7:0] strb,
                          output logic [63:0] rdat, output logic err, output longint acc_cyc);
        int n;
        sel = s; req_wr = wr; req_adr = adr; req_wdat = wdat; req_strb = strb;
        req_vld = 1'b1; rsp_rdy = 1'b1;
        #1;
        n = 0;
        while (!req_rdy && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("req_rdy_wait", {63'b0, req_rdy}, 64'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(negedge clk);
        chk("rsp_vld_next", {63'b0, rsp_vld}, 64'd1);
        rdat = rsp_rdat;
        err  = rsp_err;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        longint      ac;
        int          n;
        n_vec = 0; n_bad = 0; sel = 0;
        req_vld = 1'b0; req_wr = 1'b0; req_adr = '0; req_wdat = '0; req_strb = '0; rsp_rdy = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mtime64", mt64, 64'd0);
        chk("rst_mtime32", mt32, 64'd0);
        chk("rst_int", {61'b0, int64, int4, int32}, 64'd0);
        chk("rst_rsp", {60'b0, if64.RspValid, if64.RspErr, if32.RspValid, if64.ReqReady}, 64'd1);
        chk("rst_rdata", if64.RspRData, 64'd0);
        reset = 1'b1;

        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("mtime_count", mt64, 64'(k));
        end
        chk("int_idle", {63'b0, int64}, 64'd0);
        do_req(0, 1'b0, 16'hBFF8, 64'd0, 8'hFF, rd, er, ac);
        chk("rd_mtime", rd, 64'(ac));
        chk("rd_mtime_err", {63'b0, er}, 64'd0);

        do_req(0, 1'b1, 16'h4000, 64'd20, 8'hFF, rd, er, ac);
        chk("wr_rsp", {rd[62:0], er}, 64'd0);
        n = 0;
        while (mt64 != 64'd20 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mtime_reach20", mt64, 64'd20);
        chk("int_pre", {63'b0, int64}, 64'd0);
        @(negedge clk);
        chk("int_rise", {63'b0, int64}, 64'd1);
        do_req(0, 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, ac);
        chk("int_hold", {63'b0, int64}, 64'd1);
        @(negedge clk);
        chk("int_fall", {63'b0, int64}, 64'd0);

        n = 0;
        while (cyc < 40 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("div4_at40", mt4, 64'd10);
        repeat (3) @(negedge clk);
        chk("div4_at43", mt4, 64'd10);
        @(negedge clk);
        chk("div4_at44", mt4, 64'd11);

        do_req(0, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, ac);
        chk("wrap_fe", mt64, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_err", {63'b0, er}, 64'd0);
        @(negedge clk);
        chk("wrap_ff", mt64, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap_0", mt64, 64'd0);
        do_req(0, 1'b1, 16'hBFF8, 64'd5, 8'hFF, rd, er, ac);
        chk("wr_beats_tick", mt64, 64'd5);

        do_req(2, 1'b1, 16'hBFF8, 64'hFFFF_FFFE, 8'h0F, rd, er, ac);
        chk("x32_lo_wr", mt32, 64'h0000_0000_FFFF_FFFE);
        do_req(2, 1'b1, 16'hBFFC, 64'd1, 8'h0F, rd, er, ac);
        chk("x32_hi_wr", mt32, 64'h0000_0001_FFFF_FFFE);
        @(negedge clk);
        chk("x32_lo_ff", mt32, 64'h0000_0001_FFFF_FFFF);
        @(negedge clk);
        chk("x32_lo_wrap", mt32, 64'h0000_0002_0000_0000);
        do_req(2, 1'b1, 16'h4000, 64'hAAAA_BBBB, 8'h03, rd, er, ac);
        do_req(2, 1'b0, 16'h4000, 64'd0, 8'h0F, rd, er, ac);
        chk("x32_strb_lo", rd, 64'hFFFF_BBBB);
        do_req(2, 1'b0, 16'h4004, 64'd0, 8'h0F, rd, er, ac);
        chk("x32_strb_hi", rd, 64'hFFFF_FFFF);
        do_req(2, 1'b0, 16'h4002, 64'd0, 8'h0F, rd, er, ac);
        chk("x32_misalign", {rd[62:0], er}, 64'd1);

        do_req(0, 1'b0, 16'h4008, 64'd0, 8'hFF, rd, er, ac);
        chk("unmapped_rd", {rd[62:0], er}, 64'd1);
        do_req(0, 1'b0, 16'h4004, 64'd0, 8'hFF, rd, er, ac);
        chk("x64_misalign", {rd[62:0], er}, 64'd1);
        do_req(0, 1'b1, 16'h4008, 64'd0, 8'hFF, rd, er, ac);
        chk("unmapped_wr_err", {63'b0, er}, 64'd1);
        do_req(0, 1'b0, 16'h4000, 64'd0, 8'hFF, rd, er, ac);
        chk("unmapped_no_change", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        @(negedge clk);
        sel = 0; req_wr = 1'b0; req_adr = 16'h4008; req_vld = 1'b1; rsp_rdy = 1'b0;
        @(posedge clk); #1;
        req_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold", {rsp_rdat[60:0], rsp_vld, req_rdy, rsp_err}, 64'b101);
        end
        reset = 1'b0;
        #1;
        chk("rst_drop_rsp", {62'b0, rsp_vld, req_rdy}, 64'b01);
        chk("rst_mtime", mt64, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
